// File: rtl/sign_mag_add_arb.sv
// ============================================================================
// Module   : sign_mag_add_arb
// Purpose  : Two-requester round-robin arbiter in front of one registered
//            sign-magnitude adder (grant, calculate, done pulse).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sign_mag_add_arb #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic         req1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [N-1:0] sum,
  output logic         ovf,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         w_start;
  logic         w_sel1;

  logic         r_ptr;
  logic         r_gnt0;
  logic         r_gnt1;
  logic         r_done0;
  logic         r_done1;
  logic         r_ovf;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_sum;

  logic [N-2:0] w_mag_a;
  logic [N-2:0] w_mag_b;
  logic [N-2:0] w_max;
  logic [N-2:0] w_min;
  logic [N-2:0] w_diff;
  logic [N-2:0] w_mag;
  logic [N-1:0] w_add;
  logic         w_sign;
  logic         w_same;
  logic         w_ovf;
  logic [N-1:0] w_res;

  // Requester 1 wins when it is alone, or when both ask and the pointer favors it.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_sel1  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_start = 1'b1;
          w_sel1  = req1 && (!req0 || r_ptr);
          w_next  = S_CALC;
        end
      end
      S_CALC:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_mag_a = r_a[N-2:0];
    w_mag_b = r_b[N-2:0];
    if (w_mag_a > w_mag_b) begin
      w_max  = w_mag_a;
      w_min  = w_mag_b;
      w_sign = r_a[N-1];
    end else begin
      w_max  = w_mag_b;
      w_min  = w_mag_a;
      w_sign = r_b[N-1];
    end
    w_same = (r_a[N-1] == r_b[N-1]);
    w_add  = {1'b0, w_max} + {1'b0, w_min};
    w_diff = w_max - w_min;
    w_mag  = w_same ? w_add[N-2:0] : w_diff;
    w_ovf  = w_same & w_add[N-1];
    // A zero magnitude always carries a positive sign.
    w_res  = {w_sign & (|w_mag), w_mag};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_ovf   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a    <= w_sel1 ? a1 : a0;
            r_b    <= w_sel1 ? b1 : b0;
            r_gnt0 <= !w_sel1;
            r_gnt1 <= w_sel1;
          end
        end
        S_CALC: begin
          r_sum   <= w_res;
          r_ovf   <= w_ovf;
          r_done0 <= r_gnt0;
          r_done1 <= r_gnt1;
        end
        S_DONE: begin
          r_ptr   <= r_gnt0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign sum   = r_sum;
  assign ovf   = r_ovf;
  assign busy  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sign_mag_add_arb.sv
// ============================================================================
// Module   : tb_sign_mag_add_arb
// Purpose  : Self-checking bench for sign_mag_add_arb against an integer model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sign_mag_add_arb;

  logic       clk;
  logic       reset;
  logic       req0;
  logic       req1;
  logic [7:0] a0;
  logic [7:0] b0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [7:0] sum;
  logic       ovf;
  logic       busy;

  int   checks;
  int   errors;
  logic ptr_m;

  sign_mag_add_arb #(.N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .sum   (sum),
    .ovf   (ovf),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed integer sum, then magnitude wrap to 7 bits; returns {ovf, sum}.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int va;
    int vb;
    int s;
    int m;
    logic o;
    logic sg;
    va = int'(a[6:0]);
    vb = int'(b[6:0]);
    if (a[7]) va = -va;
    if (b[7]) vb = -vb;
    s  = va + vb;
    m  = (s < 0) ? -s : s;
    o  = (m >= 128);
    m  = m % 128;
    sg = (s < 0) && (m != 0);
    return {o, sg, m[6:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic r0, input logic r1,
                        input logic [7:0] x0, input logic [7:0] y0,
                        input logic [7:0] x1, input logic [7:0] y1,
                        input string tag);
    logic       g;
    logic [4:0] ce;
    logic [8:0] re;
    req0 = r0; req1 = r1;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    g  = (r0 && r1) ? ptr_m : r1;
    re = g ? ref_add(x1, y1) : ref_add(x0, y0);
    tick();
    ce = g ? 5'b01001 : 5'b10001;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy} !== ce) begin
      errors++;
      $display("FAIL %s grant: got gnt/done/busy=%b exp %b", tag, {gnt0, gnt1, done0, done1, busy}, ce);
    end
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    tick();
    ce = g ? 5'b01011 : 5'b10101;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy} !== ce) begin
      errors++;
      $display("FAIL %s done: got gnt/done/busy=%b exp %b", tag, {gnt0, gnt1, done0, done1, busy}, ce);
    end
    checks++;
    if ({ovf, sum} !== re) begin
      errors++;
      $display("FAIL %s result: got ovf=%b sum=%h exp ovf=%b sum=%h", tag, ovf, sum, re[8], re[7:0]);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, ovf, sum} !== {5'b00000, re}) begin
      errors++;
      $display("FAIL %s release: got ctl=%b ovf=%b sum=%h exp ctl=00000 ovf=%b sum=%h",
               tag, {gnt0, gnt1, done0, done1, busy}, ovf, sum, re[8], re[7:0]);
    end
    ptr_m = ~g;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    ptr_m = 1'b0;
    repeat (3) tick();
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, ovf, sum} !== 13'd0) begin
      errors++;
      $display("FAIL reset_values: got %b exp 0", {gnt0, gnt1, done0, done1, busy, ovf, sum});
    end
    reset = 1'b0;
    repeat (4) tick();
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, ovf, sum} !== 13'd0) begin
      errors++;
      $display("FAIL idle_no_req: got %b exp 0", {gnt0, gnt1, done0, done1, busy, ovf, sum});
    end
  endtask

  task automatic test_single_op();
    run_op(1'b1, 1'b0, 8'h05, 8'h83, 8'h00, 8'h00, "single_p5_m3");
    run_op(1'b0, 1'b1, 8'h00, 8'h00, 8'h11, 8'h22, "single_req1");
  endtask

  task automatic test_sign_cases();
    run_op(1'b1, 1'b0, 8'h05, 8'h85, 8'h00, 8'h00, "zero_norm");
    run_op(1'b1, 1'b0, 8'h83, 8'h05, 8'h00, 8'h00, "m3_p5");
    run_op(1'b0, 1'b1, 8'h00, 8'h00, 8'h85, 8'h82, "m5_m2");
    run_op(1'b1, 1'b0, 8'h80, 8'h80, 8'h00, 8'h00, "negzero_pair");
  endtask

  task automatic test_overflow();
    run_op(1'b1, 1'b0, 8'h64, 8'h32, 8'h00, 8'h00, "ovf_150");
    run_op(1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, "after_ovf");
    run_op(1'b0, 1'b1, 8'h00, 8'h00, 8'hC0, 8'hC0, "neg_ovf_wrap0");
  endtask

  task automatic test_back_to_back();
    logic       g;
    logic [4:0] ce;
    logic [8:0] r0e;
    logic [8:0] r1e;
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h0A; b0 = 8'h87; a1 = 8'h90; b1 = 8'h15;
    r0e = ref_add(8'h0A, 8'h87);
    r1e = ref_add(8'h90, 8'h15);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      g = (i % 2 == 1);
      tick();
      ce = g ? 5'b01001 : 5'b10001;
      checks++;
      if ({gnt0, gnt1, done0, done1, busy} !== ce) begin
        errors++;
        $display("FAIL b2b[%0d] grant: got %b exp %b", i, {gnt0, gnt1, done0, done1, busy}, ce);
      end
      tick();
      ce = g ? 5'b01011 : 5'b10101;
      checks++;
      if ({gnt0, gnt1, done0, done1, busy, ovf, sum} !== {ce, (g ? r1e : r0e)}) begin
        errors++;
        $display("FAIL b2b[%0d] done: got ctl=%b ovf=%b sum=%h exp ctl=%b res=%h",
                 i, {gnt0, gnt1, done0, done1, busy}, ovf, sum, ce, (g ? r1e : r0e));
      end
      if (i == 5) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
      checks++;
      if ({gnt0, gnt1, done0, done1, busy} !== 5'b00000) begin
        errors++;
        $display("FAIL b2b[%0d] gap: got %b exp 00000", i, {gnt0, gnt1, done0, done1, busy});
      end
    end
    ptr_m = 1'b0;
  endtask

  task automatic test_random();
    int         pat;
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
    for (int i = 0; i < 40; i++) begin
      pat = int'($urandom_range(1, 3));
      x0 = 8'($urandom); y0 = 8'($urandom);
      x1 = 8'($urandom); y1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) y0 = {~x0[7], x0[6:0]};
      if ($urandom_range(0, 3) == 0) y1 = {x1[7], x1[6:0]};
      run_op(pat[0], pat[1], x0, y0, x1, y1, $sformatf("rand[%0d]", i));
    end
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; a0 = 8'h33; b0 = 8'h44;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, ovf, sum} !== 13'd0) begin
      errors++;
      $display("FAIL reset_in_done: got %b exp 0", {gnt0, gnt1, done0, done1, busy, ovf, sum});
    end
    req0 = 1'b0;
    tick();
    reset = 1'b0;
    ptr_m = 1'b0;
    tick();
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, ovf, sum} !== 13'd0) begin
      errors++;
      $display("FAIL after_reset_idle: got %b exp 0", {gnt0, gnt1, done0, done1, busy, ovf, sum});
    end
  endtask

  task automatic test_abort();
    run_op(1'b1, 1'b0, 8'h07, 8'h02, 8'h00, 8'h00, "pre_abort");
    req1 = 1'b1; a1 = 8'h12; b1 = 8'h34;
    tick();
    checks++;
    if ({gnt0, gnt1, done0, done1, busy} !== 5'b01001) begin
      errors++;
      $display("FAIL abort_calc: got %b exp 01001", {gnt0, gnt1, done0, done1, busy});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, ovf, sum} !== 13'd0) begin
      errors++;
      $display("FAIL abort_reset: got %b exp 0", {gnt0, gnt1, done0, done1, busy, ovf, sum});
    end
    req1 = 1'b0;
    tick();
    reset = 1'b0;
    ptr_m = 1'b0;
    tick();
    tick();
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, ovf, sum} !== 13'd0) begin
      errors++;
      $display("FAIL abort_no_done: got %b exp 0", {gnt0, gnt1, done0, done1, busy, ovf, sum});
    end
    run_op(1'b1, 1'b1, 8'h06, 8'h81, 8'h12, 8'h34, "abort_rereq");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_op();
    test_sign_cases();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
